// File: rtl/pong_score_display.sv
// Pong scoreboard: BCD scores for both players, attract/play/win phase FSM, blinking winner digits.
// All outputs registered; they follow the causing input edge by one clock.
module pong_score_display #(
  parameter int WIN_SCORE    = 11,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       playing,
  output logic       game_over,
  output logic       winner
);

  localparam int CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [3:0] BLANK = 4'hE;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WIN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [3:0]      p1_ones_q, p1_ones_d, p1_tens_q, p1_tens_d;
  logic [3:0]      p2_ones_q, p2_ones_d, p2_tens_q, p2_tens_d;
  logic [6:0]      p1_cnt_q, p1_cnt_d, p2_cnt_q, p2_cnt_d;
  logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_ph_q, blink_ph_d;
  logic            winner_q, winner_d;
  logic [3:0]      digit3_q, digit2_q, digit1_q, digit0_q;
  logic [3:0]      digit3_d, digit2_d, digit1_d, digit0_d;
  logic            playing_q, playing_d, game_over_q, game_over_d;
  logic            p1_inc, p2_inc, p1_win, p2_win, clear;

  assign p1_inc = (state_q == PLAY) && p1_point;
  assign p2_inc = (state_q == PLAY) && p2_point;
  assign p1_win = p1_inc && (p1_cnt_q + 7'd1 == 7'(WIN_SCORE));
  assign p2_win = p2_inc && (p2_cnt_q + 7'd1 == 7'(WIN_SCORE));
  assign clear  = (state_q != PLAY) && start;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      p1_ones_q   <= '0;
      p1_tens_q   <= '0;
      p1_cnt_q    <= '0;
      p2_ones_q   <= '0;
      p2_tens_q   <= '0;
      p2_cnt_q    <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      winner_q    <= 1'b0;
      digit3_q    <= 4'hA;
      digit2_q    <= 4'hB;
      digit1_q    <= 4'hC;
      digit0_q    <= 4'hD;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_ones_q   <= p1_ones_d;
      p1_tens_q   <= p1_tens_d;
      p1_cnt_q    <= p1_cnt_d;
      p2_ones_q   <= p2_ones_d;
      p2_tens_q   <= p2_tens_d;
      p2_cnt_q    <= p2_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      winner_q    <= winner_d;
      digit3_q    <= digit3_d;
      digit2_q    <= digit2_d;
      digit1_q    <= digit1_d;
      digit0_q    <= digit0_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PLAY;
      PLAY:    if (p1_win || p2_win) state_d = WIN;
      WIN:     if (start) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  // Score, blink and winner datapath
  always_comb begin
    p1_ones_d   = p1_ones_q;
    p1_tens_d   = p1_tens_q;
    p1_cnt_d    = p1_cnt_q;
    p2_ones_d   = p2_ones_q;
    p2_tens_d   = p2_tens_q;
    p2_cnt_d    = p2_cnt_q;
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    winner_d    = winner_q;
    if (clear) begin
      p1_ones_d = '0;
      p1_tens_d = '0;
      p1_cnt_d  = '0;
      p2_ones_d = '0;
      p2_tens_d = '0;
      p2_cnt_d  = '0;
      winner_d  = 1'b0;
    end
    if (p1_inc) begin
      p1_cnt_d = p1_cnt_q + 7'd1;
      if (p1_ones_q == 4'd9) begin
        p1_ones_d = '0;
        p1_tens_d = p1_tens_q + 4'd1;
      end else begin
        p1_ones_d = p1_ones_q + 4'd1;
      end
    end
    if (p2_inc) begin
      p2_cnt_d = p2_cnt_q + 7'd1;
      if (p2_ones_q == 4'd9) begin
        p2_ones_d = '0;
        p2_tens_d = p2_tens_q + 4'd1;
      end else begin
        p2_ones_d = p2_ones_q + 4'd1;
      end
    end
    if (state_q == PLAY && state_d == WIN) winner_d = !p1_win;
    // Counter and phase only run while staying in WIN, so any entry starts from zero
    if (state_q == WIN && state_d == WIN) begin
      if (blink_cnt_q == CW'(BLINK_CYCLES - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = !blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
      end
    end
  end

  // Output logic, computed from next-state values so registers track the same edge
  always_comb begin
    playing_d   = (state_d == PLAY);
    game_over_d = (state_d == WIN);
    digit3_d    = (p1_tens_d == 4'd0) ? BLANK : p1_tens_d;
    digit2_d    = p1_ones_d;
    digit1_d    = (p2_tens_d == 4'd0) ? BLANK : p2_tens_d;
    digit0_d    = p2_ones_d;
    if (state_d == IDLE) begin
      digit3_d = 4'hA;
      digit2_d = 4'hB;
      digit1_d = 4'hC;
      digit0_d = 4'hD;
    end else if (state_d == WIN && blink_ph_d) begin
      if (winner_d) begin
        digit1_d = BLANK;
        digit0_d = BLANK;
      end else begin
        digit3_d = BLANK;
        digit2_d = BLANK;
      end
    end
  end

  assign digit3    = digit3_q;
  assign digit2    = digit2_q;
  assign digit1    = digit1_q;
  assign digit0    = digit0_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_score_display.sv
// Scoreboard bench for pong_score_display with WIN_SCORE=11, BLINK_CYCLES=4.
module tb_pong_score_display;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       playing, game_over, winner;

  pong_score_display #(.WIN_SCORE(11), .BLINK_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .p1_point(p1_point), .p2_point(p2_point),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .playing(playing), .game_over(game_over), .winner(winner)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic [15:0] d;
    logic        pl;
    logic        go;
    logic        w;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: at each falling edge, check every expectation due for this cycle
  initial begin
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].tag <= cyc) begin
        exp_t e;
        logic [15:0] got;
        e   = q.pop_front();
        got = {digit3, digit2, digit1, digit0};
        n_cmp++;
        if (e.tag != cyc || got !== e.d || playing !== e.pl ||
            game_over !== e.go || winner !== e.w) begin
          n_bad++;
          $display("FAIL %s: got digits=%h playing=%b game_over=%b winner=%b, expected digits=%h playing=%b game_over=%b winner=%b",
                   e.nm, got, playing, game_over, winner, e.d, e.pl, e.go, e.w);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic a, input logic b);
    @(negedge clock);
    reset    = r;
    start    = s;
    p1_point = a;
    p2_point = b;
  endtask

  // Expectation for the outputs after the edge that samples the values just driven
  task automatic expect_next(input string nm, input logic [15:0] d,
                             input logic pl, input logic go, input logic w);
    exp_t e;
    e.nm = nm; e.d = d; e.pl = pl; e.go = go; e.w = w; e.tag = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 0, 1, 1);  expect_next("reset_state", 16'hABCD, 0, 0, 0);
    drive(1, 0, 0, 0);
    idle(9);
    drive(0, 0, 0, 0);  expect_next("idle_10", 16'hABCD, 0, 0, 0);
    drive(0, 0, 1, 1);  expect_next("idle_points_ignored", 16'hABCD, 0, 0, 0);
    drive(0, 0, 0, 0);  expect_next("idle_after_points", 16'hABCD, 0, 0, 0);
    drive(0, 1, 0, 0);  expect_next("start_play", 16'hE0E0, 1, 0, 0);

    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0); drive(0, 0, 0, 0); end
    for (int i = 0; i < 9; i++) begin drive(0, 0, 0, 1); drive(0, 0, 0, 0); end
    expect_next("p1_3_p2_9", 16'hE3E9, 1, 0, 0);
    drive(0, 0, 0, 1);  expect_next("p2_carry_to_10", 16'hE310, 1, 0, 0);
    drive(0, 1, 0, 0);  expect_next("start_in_play_ignored", 16'hE310, 1, 0, 0);
    drive(0, 1, 1, 0);  expect_next("start_plus_point_in_play", 16'hE410, 1, 0, 0);
    drive(0, 0, 0, 1);  expect_next("p2_wins", 16'hE411, 0, 1, 1);

    idle(2);
    drive(0, 0, 0, 0);  expect_next("blink_e3_phase0", 16'hE411, 0, 1, 1);
    drive(0, 0, 0, 0);  expect_next("blink_e4_phase1", 16'hE4EE, 0, 1, 1);
    drive(0, 0, 1, 0);  expect_next("win_p1_ignored", 16'hE4EE, 0, 1, 1);
    drive(0, 0, 0, 1);  expect_next("win_p2_ignored", 16'hE4EE, 0, 1, 1);
    drive(0, 0, 0, 0);  expect_next("blink_e7_phase1", 16'hE4EE, 0, 1, 1);
    drive(0, 0, 0, 0);  expect_next("blink_e8_phase0", 16'hE411, 0, 1, 1);
    drive(0, 1, 1, 0);  expect_next("start_in_win", 16'hE0E0, 1, 0, 0);

    // Both held high: one count per cycle each
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);  expect_next("both_at_10", 16'h1010, 1, 0, 0);
    drive(0, 0, 1, 1);  expect_next("tie_win_p1_priority", 16'h1111, 0, 1, 0);
    idle(3);
    drive(0, 0, 0, 0);  expect_next("p1_winner_blanked", 16'hEE11, 0, 1, 0);

    drive(0, 1, 0, 0);  expect_next("restart", 16'hE0E0, 1, 0, 0);
    drive(0, 0, 1, 0);  expect_next("p1_one", 16'hE1E0, 1, 0, 0);
    drive(1, 0, 1, 0);  expect_next("reset_mid_game", 16'hABCD, 0, 0, 0);
    drive(0, 0, 1, 1);  expect_next("idle_after_reset", 16'hABCD, 0, 0, 0);
    drive(0, 1, 0, 0);  expect_next("start_after_reset", 16'hE0E0, 1, 0, 0);
    drive(0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d expectations pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_score_display.md
Name: pong_score_display

Overview:
- Scoreboard controller for the Pong game.
- Holds both players' scores as BCD and runs the game-phase state machine (attract / play / win).
- Produces four registered 4-bit digit codes that feed four hex-to-seven-segment decoder instances.
- Code map:
  - 0x0-0x9: numerals.
  - 0xA/0xB/0xC/0xD: "P"/"o"/"n"/"g".
  - 0xE: blank segment.

Parameters:
- WIN_SCORE, 11: points needed to win. Legal range 1..99.
- BLINK_CYCLES, 25000000: clock cycles per blink half-period in the WIN state. Minimum 2.

Ports:
- clock  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse: start a new game.
- p1_point  input  1  single-cycle pulse: player 1 scored.
- p2_point  input  1  single-cycle pulse: player 2 scored.
- digit3  output  4  code for the leftmost display (player 1 tens).
- digit2  output  4  code for player 1 ones.
- digit1  output  4  code for player 2 tens.
- digit0  output  4  code for the rightmost display (player 2 ones).
- playing  output  1  high while in PLAY.
- game_over  output  1  high while in WIN.
- winner  output  1  0 = player 1, 1 = player 2. Valid while game_over=1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset values:
  - state IDLE; all scores 0; blink counter 0; blink phase 0.
  - digit3..0 = A, B, C, D.
  - playing=0, game_over=0, winner=0.
- Reset asserted mid-game returns to these values on the next edge, regardless of the other inputs.
- Score storage: per player, a BCD ones digit, a BCD tens digit and a 7-bit binary count. All three update together.
- Score increment:
  - ones 9 -> 0 with tens+1.
  - A count never exceeds WIN_SCORE, so no wrap past 99 is possible.
- All outputs are registered. Digits, playing, game_over and winner reflect the state/score one cycle after the causing input edge.
- IDLE (attract):
  - Digits show A, B, C, D ("PonG").
  - Point pulses are ignored.
  - start=1 -> PLAY, all scores cleared.
- PLAY:
  - playing=1.
  - p1_point=1 increments player 1; p2_point=1 increments player 2.
  - If both are high in the same cycle, both increment in that cycle.
  - start is ignored.
  - If a post-increment binary count equals WIN_SCORE -> WIN, with winner set to that player.
  - If both reach WIN_SCORE in the same cycle, winner=0 (player 1 priority).
  - Display: digit3 = p1 tens, or E if p1 tens=0 (leading-zero blanking); digit2 = p1 ones; digit1 = p2 tens, or E if 0; digit0 = p2 ones.
- WIN:
  - game_over=1, playing=0. Final scores are held. Point pulses are ignored.
  - Blink counter runs 0..BLINK_CYCLES-1 and is cleared on entry to WIN.
  - On the wrap from BLINK_CYCLES-1 to 0, the blink phase toggles. Phase is 0 on entry.
  - Phase 0: all four digits show scores as in PLAY.
  - Phase 1: the winner's two digits show E; the loser's digits stay steady.
  - start=1 -> PLAY: scores cleared, game_over=0, blink counter and phase cleared.
- Point inputs have no edge detection. An input held high counts once per cycle; pulse shaping is an upstream responsibility.
- Point input and start in the same cycle:
  - In IDLE/WIN, start wins and points are ignored.
  - In PLAY, start is ignored and points count.

Test Plan:
- Reset, then idle 10 cycles -> digits A,B,C,D; playing=0; game_over=0.
- start pulse, then 3 p1_point pulses and 12 p2_point pulses (WIN_SCORE=20) -> digits E,3,1,2; playing=1.
- WIN_SCORE=11, BLINK_CYCLES=4: start, then 11 p2_point pulses:
  - -> game_over=1, winner=1; digits E,0,1,1.
  - After 4 cycles -> digits E,0,E,E.
  - After 4 more cycles -> E,0,1,1 again.
- WIN_SCORE=11: bring both players to 10, then assert p1_point and p2_point in the same cycle -> game_over=1, winner=0; digits 1,1,1,1 (phase 0).
- Point pulses in IDLE, and in WIN after a win -> scores and digits unchanged. start in WIN -> digits E,0,E,0; game_over=0; playing=1.
- reset asserted in PLAY with p1_point=1 in the same cycle -> next cycle: IDLE, digits A,B,C,D, and the score is not incremented.
